// File: rtl/ahb_arbiter_if.sv
// AHB arbiter bus bundle: request/lock/transfer inputs and grant/ownership outputs.
// The "slave" modport is the arbiter side; the "master" modport is the requester side.
interface ahb_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  localparam int unsigned MASTER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MASTER_W-1:0]    HMASTER;
  logic                   HMASTLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: registered one-hot grant, burst/lock tracking, HMASTER/HMASTLOCK.
// Optional feature: define AHB_ARB_ROUND_ROBIN_EN for rotating priority
// (search starts after the last granted master); default is fixed lowest-index priority.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS = 4
) (
  input  logic         HCLK,
  input  logic         HRESET,
  ahb_arbiter_if.slave bus
);

  localparam int unsigned MASTER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_W    = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_LOCK  = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MASTER_W-1:0]    hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;

  logic [MASTER_W-1:0]    owner_idx;
  logic [MASTER_W-1:0]    win_idx;
  logic                   win_found;
  logic                   arb_en;
  logic [CNT_W-1:0]       burst_last;

  // Index of the currently granted master
  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) owner_idx = MASTER_W'(i);
    end
  end

  // Beats minus one for fixed-length bursts; zero for SINGLE/INCR
  always_comb begin
    case (bus.HBURST)
      3'd2, 3'd3: burst_last = CNT_W'(3);
      3'd4, 3'd5: burst_last = CNT_W'(7);
      3'd6, 3'd7: burst_last = CNT_W'(15);
      default:    burst_last = '0;
    endcase
  end

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [MASTER_W-1:0] ptr_q, ptr_d;
  logic [MASTER_W-1:0] cand;

  // Rotating-priority search starting just after the last winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = MASTER_W'((32'(ptr_q) + 32'd1 + k) % NUM_MASTERS);
      if (!win_found && bus.HBUSREQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer follows every arbitration point that grants a requester
  always_comb begin
    ptr_d = ptr_q;
    if (arb_en && win_found) ptr_d = win_idx;
  end

  // Round-robin pointer register
  always_ff @(posedge HCLK) begin
    if (HRESET) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Fixed-priority search: lowest requesting index wins
  always_comb begin
    win_found = |bus.HBUSREQ;
    win_idx   = '0;
    for (int k = int'(NUM_MASTERS) - 1; k >= 0; k--) begin
      if (bus.HBUSREQ[k]) win_idx = MASTER_W'(k);
    end
  end
`endif

  // Next-state, beat counter, grant and address-phase ownership
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    arb_en      = 1'b0;

    if (bus.HREADY) begin
      hmaster_d   = owner_idx;
      hmastlock_d = (state_q == ST_LOCK);

      case (state_q)
        ST_IDLE: arb_en = 1'b1;
        ST_OWN: begin
          if (bus.HTRANS == TR_IDLE || !bus.HBUSREQ[owner_idx]) begin
            arb_en = 1'b1;
          end else if (bus.HTRANS == TR_NONSEQ && burst_last != '0) begin
            state_d = ST_BURST;
            cnt_d   = burst_last;
          end
        end
        ST_BURST: begin
          case (bus.HTRANS)
            TR_IDLE: arb_en = 1'b1;
            TR_SEQ: begin
              cnt_d = cnt_q - CNT_W'(1);
              // Last-beat address phase: hand off early
              if (cnt_q == CNT_W'(1)) arb_en = 1'b1;
            end
            TR_NONSEQ: begin
              cnt_d = burst_last;
              if (burst_last == '0) state_d = ST_OWN;
            end
            default: ;
          endcase
        end
        ST_LOCK: begin
          if (!bus.HLOCK[owner_idx]) state_d = ST_OWN;
        end
        default: state_d = ST_IDLE;
      endcase

      if (arb_en) begin
        cnt_d = '0;
        if (win_found) begin
          grant_d = NUM_MASTERS'(1) << win_idx;
          state_d = bus.HLOCK[win_idx] ? ST_LOCK : ST_OWN;
        end else begin
          grant_d = NUM_MASTERS'(1);
          state_d = ST_IDLE;
        end
      end
    end else if (state_q == ST_IDLE) begin
      // Parked bus may still move its grant during wait states
      grant_d = win_found ? (NUM_MASTERS'(1) << win_idx) : NUM_MASTERS'(1);
    end
  end

  // State and output registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      grant_q     <= NUM_MASTERS'(1);
      hmaster_q   <= '0;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus random traffic,
// expected outputs from a behavioural model queued and checked by a monitor.
module tb_ahb_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned MW = 2;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [MW-1:0] master;
    logic          lock;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESET;

  always #5 HCLK = ~HCLK;

  ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_arbiter #(.NUM_MASTERS(N)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors    = 0;
  int    miscompares = 0;

  // Behavioural model: who owns the bus, whether locked, and burst progress in beats
  int m_owner;
  bit m_parked;
  bit m_locked;
  int m_blen;
  int m_issued;
  int m_master;
  bit m_mlock;
  int m_ptr;

  function automatic int beats_of(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 0;
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] req);
    int idx;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < int'(N); k++) begin
      idx = (m_ptr + 1 + k) % int'(N);
      if (req[idx]) return idx;
    end
`else
    for (int k = 0; k < int'(N); k++) begin
      idx = k;
      if (req[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic model(input logic [N-1:0] req, input logic [N-1:0] lock,
                       input logic [1:0] trans, input logic [2:0] burst,
                       input logic ready, input logic rst);
    int w;
    int len;
    bit handoff;
    if (rst) begin
      m_owner = 0; m_parked = 1; m_locked = 0; m_blen = 0; m_issued = 0;
      m_master = 0; m_mlock = 0; m_ptr = 0;
      return;
    end
    w = pick(req);
    len = beats_of(burst);
    handoff = 0;
    if (!ready) begin
      if (m_parked) m_owner = (w < 0) ? 0 : w;
      return;
    end
    m_master = m_owner;
    m_mlock  = m_locked;
    if (m_parked) begin
      handoff = 1;
    end else if (m_locked) begin
      if (!lock[m_owner]) m_locked = 0;
    end else if (m_blen > 0) begin
      if (trans == 2'd0) handoff = 1;
      else if (trans == 2'd3) begin
        m_issued++;
        if (m_issued == m_blen) handoff = 1;
      end else if (trans == 2'd2) begin
        m_blen   = len;
        m_issued = (len > 0) ? 1 : 0;
      end
    end else begin
      if (trans == 2'd0 || !req[m_owner]) handoff = 1;
      else if (trans == 2'd2 && len > 0) begin
        m_blen   = len;
        m_issued = 1;
      end
    end
    if (handoff) begin
      m_blen = 0;
      m_issued = 0;
      if (w < 0) begin
        m_owner = 0; m_parked = 1; m_locked = 0;
      end else begin
        m_owner = w; m_parked = 0; m_locked = lock[w]; m_ptr = w;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic step(input string nm, input logic [N-1:0] req, input logic [N-1:0] lock,
                      input logic [1:0] trans, input logic [2:0] burst,
                      input logic ready, input logic rst);
    exp_t e;
    @(negedge HCLK);
    HRESET      = rst;
    bus.HBUSREQ = req;
    bus.HLOCK   = lock;
    bus.HTRANS  = trans;
    bus.HBURST  = burst;
    bus.HREADY  = ready;
    model(req, lock, trans, burst, ready, rst);
    e.grant  = N'(1) << m_owner;
    e.master = MW'(m_master);
    e.lock   = m_mlock;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  exp_t  mon_e;
  string mon_nm;

  // Monitor: compare DUT outputs shortly after each rising edge
  initial begin
    forever begin
      @(posedge HCLK);
      #2;
      if (exp_q.size() != 0) begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        vectors++;
        if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK} !== mon_e) begin
          miscompares++;
          $display("FAIL %s @%0t: got HGRANT=%b HMASTER=%0d HMASTLOCK=%b, want HGRANT=%b HMASTER=%0d HMASTLOCK=%b",
                   mon_nm, $time, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK,
                   mon_e.grant, mon_e.master, mon_e.lock);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [N-1:0] r;
    logic [N-1:0] l;
    HRESET      = 1'b1;
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS  = 2'd0;
    bus.HBURST  = 3'd0;
    bus.HREADY  = 1'b1;

    // Reset held with random inputs, then release
    for (int i = 0; i < 3; i++) begin
      r = N'($urandom);
      l = N'($urandom);
      step("reset", r, l, 2'($urandom), 3'($urandom), 1'($urandom), 1'b1);
    end

    // Simultaneous requests from IDLE, then master 1 drops out
    step("simul", 4'b1010, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    step("simul", 4'b1010, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    step("simul", 4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    step("simul", 4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);

    // INCR8 by master 2, master 0 requests from beat 2, two wait states mid-burst
    step("incr8", 4'b0100, 4'b0000, 2'd0, 3'd5, 1'b1, 1'b0);
    step("incr8", 4'b0100, 4'b0000, 2'd2, 3'd5, 1'b1, 1'b0);
    for (int b = 2; b <= 8; b++) begin
      if (b == 5) begin
        step("incr8_wait", 4'b0101, 4'b0000, 2'd3, 3'd5, 1'b0, 1'b0);
        step("incr8_wait", 4'b0101, 4'b0000, 2'd3, 3'd5, 1'b0, 1'b0);
      end
      step("incr8", 4'b0101, 4'b0000, 2'd3, 3'd5, 1'b1, 1'b0);
    end
    step("incr8_done", 4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);

    // Locked sequence by master 3 while master 0 keeps requesting
    step("lock", 4'b1000, 4'b1000, 2'd0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("lock", 4'b1001, 4'b1000, 2'd2, 3'd0, 1'b1, 1'b0);
    step("lock_drop", 4'b1001, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    step("lock_drop", 4'b1001, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    step("lock_drop", 4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);

    // WRAP4 by master 0 aborted by IDLE on beat 2, master 2 takes over
    step("abort", 4'b0101, 4'b0000, 2'd2, 3'd2, 1'b1, 1'b0);
    step("abort", 4'b0100, 4'b0000, 2'd0, 3'd2, 1'b1, 1'b0);
    step("abort", 4'b0100, 4'b0000, 2'd1, 3'd0, 1'b1, 1'b0);

    // Owner 2 releases, nobody requests
    step("noreq", 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    step("noreq", 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);

    // Parked bus moves its grant during wait states
    step("idle_wait", 4'b0100, 4'b0000, 2'd0, 3'd0, 1'b0, 1'b0);
    step("idle_wait", 4'b0100, 4'b0000, 2'd0, 3'd0, 1'b0, 1'b0);
    step("idle_wait", 4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);

    // Reset in the middle of an INCR16 burst
    step("rst_burst", 4'b0100, 4'b0000, 2'd2, 3'd7, 1'b1, 1'b0);
    step("rst_burst", 4'b0100, 4'b0000, 2'd3, 3'd7, 1'b1, 1'b0);
    step("rst_burst", 4'b0100, 4'b0000, 2'd3, 3'd7, 1'b1, 1'b1);
    step("rst_burst", 4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = N'($urandom);
      l = r & N'($urandom) & N'($urandom);
      step("random", r, l, 2'($urandom), 3'($urandom),
           1'($urandom_range(4, 0) != 0), 1'($urandom_range(199, 0) == 0));
    end

    repeat (2) @(posedge HCLK);
    #5;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
